mist_dump_ctrl: RTL
===================

// Module: mist_dump_ctrl
// PURPOSE
//  Synthesizable frame-window scheduler for signal capture in the MiST game harness.
//  Counts frames on falling VGA_VS edges and arms a capture window at a programmed start frame.
//  Emits dump_on/dump_off pulses and a level dump_en, which gate the simulation dumper or an on-chip trace buffer.
//  Sits beside the game top; frame_cnt output is the harness-wide frame counter.
// PARAMETERS
//  FRAME_W  32  width of frame counter and start_frame
//  LEN_W    16  width of dump_len (window length in frames)
//  BLINK_B  4   frame_cnt bit driving led blink while ARMED
// PORTS
//  clk          in   1        system clock, single domain
//  rst_n        in   1        synchronous reset, active low
//  vga_vs       in   1        vertical sync, unsynchronised; falling edge = new frame
//  arm          in   1        1-cycle pulse: latch start_frame/dump_len, enter ARMED
//  stop         in   1        1-cycle pulse: abort ARMED or end DUMP
//  start_frame  in   FRAME_W  frame number at which capture opens
//  dump_len     in   LEN_W    frames to capture; 0 = unlimited until stop
//  frame_cnt    out  FRAME_W  frames seen since reset
//  dump_en      out  1        high while window open
//  dump_on      out  1        1-cycle pulse, window opens
//  dump_off     out  1        1-cycle pulse, window closes
//  busy         out  1        state is ARMED or DUMP
//  done         out  1        state is DONE
//  led          out  1        dump_en | (ARMED & frame_cnt[BLINK_B])
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, frame_cnt 0, latched regs 0. Reset in DUMP drops dump_en, no dump_off.
//  vga_vs passes through 2 sync flops; falling edge of synced value -> frame_tick (1 cycle).
//   frame_tick is 3 clk after the vga_vs fall. frame_cnt increments on frame_tick and wraps modulo 2^FRAME_W.
//  FSM: IDLE, ARMED, DUMP, DONE; all outputs registered.
//   IDLE/DONE + arm  -> ARMED: start_q<=start_frame, len_q<=dump_len.
//   ARMED + frame_tick & frame_cnt==start_q -> DUMP. Compare uses pre-increment value.
//    Same cycle: dump_on=1, dump_en=1, rem<=len_q.
//   ARMED + stop -> IDLE, no pulses.
//   DUMP + frame_tick: if len_q!=0, rem decrements. If rem==1 before the decrement -> DONE, dump_off=1, dump_en=0.
//   DUMP + stop -> DONE, dump_off=1, dump_en=0 next cycle.
//   DONE holds until arm (re-arm) or reset.
//  Boundaries:
//   arm in ARMED/DUMP is ignored; latched values unchanged.
//   arm & stop in the same cycle: stop wins; arm is dropped.
//   stop & closing frame_tick in DUMP together: one dump_off only.
//   start_q < frame_cnt at arm: waits for counter wrap, no special case.
//   start_q == frame_cnt at arm: triggers on the next frame_tick.
//   dump_len==1: window is exactly one frame. dump_len==0: never self-closes.
//  dump_on/dump_off never both high; each lasts exactly one clk.
// STRUCTURE
//  Package mist_dump_pkg: state enum {IDLE,ARMED,DUMP,DONE}, default FRAME_W/LEN_W localparams.
//  Sub-module mist_vs_edge: 2-flop sync + falling-edge detect, output frame_tick.
//  The top holds the FSM, frame counter, remaining counter and output regs.
// TESTING
//  1. Reset, 5 vga_vs falls -> frame_cnt==5. dump_en, dump_on, dump_off, busy, done stay 0.
//  2. arm start=3 len=2 at frame_cnt 0 -> dump_on on the tick with frame_cnt==3.
//     dump_en high for 2 frames; dump_off on the tick leaving frame_cnt 6; done=1.
//  3. arm start=10 len=0, run 50 frames -> dump_en stays high; stop -> dump_off next cycle, done=1.
//  4. arm start=8, stop at frame 4 -> IDLE, no dump_on ever, led blinking stops.
//  5. arm & stop same cycle in IDLE -> stays IDLE. arm while DUMP with new start -> ignored, window unchanged.
//  6. rst_n low mid-DUMP -> next cycle all outputs 0, frame_cnt 0, no dump_off.
//     Preset frame_cnt near 2^FRAME_W-1, arm start=1 -> triggers after wrap.

Source files
------------

// File: rtl/mist_dump_pkg.sv
// Shared types and default widths for the MiST frame-window capture scheduler.
package mist_dump_pkg;

    localparam int FRAME_W_DEF = 32;
    localparam int LEN_W_DEF   = 16;
    localparam int BLINK_B_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/mist_vs_edge.sv
// Synchronises the asynchronous vertical sync and emits a one-cycle tick per falling edge.
module mist_vs_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vga_vs,
    output logic frame_tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic tick_q,  tick_d;

    always_comb begin
        sync1_d = vga_vs;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = prev_q & ~sync2_q;
    end

    // Flops clear to 0 so a sync already high at reset release never looks like a fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/mist_dump_ctrl.sv
// Frame counter plus capture-window FSM: arms at a start frame and opens dump_en for dump_len frames.
module mist_dump_ctrl
    import mist_dump_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int BLINK_B = BLINK_B_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vga_vs,
    input  logic               arm,
    input  logic               stop,
    input  logic [FRAME_W-1:0] start_frame,
    input  logic [LEN_W-1:0]   dump_len,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               dump_en,
    output logic               dump_on,
    output logic               dump_off,
    output logic               busy,
    output logic               done,
    output logic               led
);

    logic frame_tick;

    dump_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0] start_q, start_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               dump_en_q, dump_en_d;
    logic               dump_on_q, dump_on_d;
    logic               dump_off_q, dump_off_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               led_q, led_d;
    logic               last_frame;

    mist_vs_edge u_vs_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_vs     (vga_vs),
        .frame_tick (frame_tick)
    );

    // A zero length means the window only closes on stop.
    assign last_frame = frame_tick && (len_q != '0) && (rem_q == LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        len_d       = len_q;
        rem_d       = rem_q;
        dump_on_d   = 1'b0;
        dump_off_d  = 1'b0;
        frame_cnt_d = frame_tick ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (arm && !stop) begin
                    state_d = ARMED;
                    start_d = start_frame;
                    len_d   = dump_len;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (frame_tick && (frame_cnt_q == start_q)) begin
                    state_d   = DUMP;
                    dump_on_d = 1'b1;
                    rem_d     = len_q;
                end
            end
            DUMP: begin
                if (frame_tick && (len_q != '0)) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                if (stop || last_frame) begin
                    state_d    = DONE;
                    dump_off_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        dump_en_d = (state_d == DUMP);
        busy_d    = (state_d == ARMED) || (state_d == DUMP);
        done_d    = (state_d == DONE);
        led_d     = dump_en_d || ((state_d == ARMED) && frame_cnt_d[BLINK_B]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            start_q     <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            dump_en_q   <= 1'b0;
            dump_on_q   <= 1'b0;
            dump_off_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            start_q     <= start_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            dump_en_q   <= dump_en_d;
            dump_on_q   <= dump_on_d;
            dump_off_q  <= dump_off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            led_q       <= led_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign dump_en   = dump_en_q;
    assign dump_on   = dump_on_q;
    assign dump_off  = dump_off_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign led       = led_q;

endmodule
